// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Holds the PC, drives instruction memory, and hands the latched word and opcode to decode.
module fetch_stage #(
    parameter int unsigned          INSTR_W  = 16,
    parameter int unsigned          ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0,
    parameter int unsigned          PC_STEP  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                imem_en,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [ADDR_W-1:0]   if_id_pc,
    output logic                if_id_valid,
    output logic [3:0]          opcode
);

    localparam int unsigned OP_W = 4;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]     if_id_instr_q, if_id_instr_d;
    logic [ADDR_W-1:0]      if_id_pc_q, if_id_pc_d;
    logic                   if_id_valid_q, if_id_valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            if_id_instr_q <= '0;
            if_id_pc_q    <= '0;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    // Next state: redirect flushes IF/ID, stall holds everything, otherwise advance one word.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_valid_d = if_id_valid_q;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect) begin
                    pc_d          = redirect_pc;
                    if_id_instr_d = '0;
                    if_id_pc_d    = '0;
                    if_id_valid_d = 1'b0;
                end else if (!stall) begin
                    pc_d          = pc_q + ADDR_W'(PC_STEP);
                    if_id_instr_d = imem_rdata;
                    if_id_pc_d    = pc_q;
                    if_id_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign imem_en     = (state_q == RUN);
    assign imem_addr   = pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_valid = if_id_valid_q;
    // Bubbles decode as opcode 0 so downstream control is a no-op.
    assign opcode      = if_id_valid_q ? if_id_instr_q[INSTR_W-1 -: OP_W] : 4'b0000;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, stall, redirect, PC wrap, mid-run reset.
module tb_fetch_stage;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned ADDR_W  = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                stall;
    logic                redirect;
    logic [ADDR_W-1:0]   redirect_pc;
    logic                imem_en;
    logic [ADDR_W-1:0]   imem_addr;
    logic [INSTR_W-1:0]  imem_rdata;
    logic [INSTR_W-1:0]  if_id_instr;
    logic [ADDR_W-1:0]   if_id_pc;
    logic                if_id_valid;
    logic [3:0]          opcode;

    logic [INSTR_W-1:0]  imem [256];
    int                  n_total = 0;
    int                  n_bad   = 0;

    fetch_stage #(
        .INSTR_W (INSTR_W),
        .ADDR_W  (ADDR_W),
        .RESET_PC(8'h00),
        .PC_STEP (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .if_id_instr(if_id_instr),
        .if_id_pc   (if_id_pc),
        .if_id_valid(if_id_valid),
        .opcode     (opcode)
    );

    always #5 clk = ~clk;

    assign imem_rdata = imem[imem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full IF/ID snapshot: pc, valid, if_id_pc, if_id_instr, opcode.
    task automatic chk_all(input string tag, input logic [7:0] pc, input logic v,
                           input logic [7:0] ipc, input logic [15:0] ins, input logic [3:0] op);
        chk({tag, ".pc"},     32'(imem_addr),   32'(pc));
        chk({tag, ".valid"},  32'(if_id_valid), 32'(v));
        chk({tag, ".if_pc"},  32'(if_id_pc),    32'(ipc));
        chk({tag, ".instr"},  32'(if_id_instr), 32'(ins));
        chk({tag, ".opcode"}, 32'(opcode),      32'(op));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'h3000 | 16'(i);
        imem[8'h00] = 16'h1234;
        imem[8'h01] = 16'h5678;
        imem[8'h02] = 16'h9ABC;
        imem[8'h03] = 16'hF00D;
        imem[8'h40] = 16'h7ABC;
        imem[8'hFF] = 16'hC0FF;

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // Reset held two cycles
        tick(); tick();
        chk_all("rst", 8'h00, 1'b0, 8'h00, 16'h0000, 4'h0);
        chk("rst.imem_en", 32'(imem_en), 32'd0);
        rst = 1'b0;
        tick();
        chk_all("boot", 8'h00, 1'b0, 8'h00, 16'h0000, 4'h0);
        chk("boot.imem_en", 32'(imem_en), 32'd1);

        // Stream four words
        tick(); chk_all("s0", 8'h01, 1'b1, 8'h00, 16'h1234, 4'h1);
        tick(); chk_all("s1", 8'h02, 1'b1, 8'h01, 16'h5678, 4'h5);
        tick(); chk_all("s2", 8'h03, 1'b1, 8'h02, 16'h9ABC, 4'h9);
        tick(); chk_all("s3", 8'h04, 1'b1, 8'h03, 16'hF00D, 4'hF);

        // Redirect back to 0 and refetch up to 0x5678
        redirect = 1'b1; redirect_pc = 8'h00;
        tick(); chk_all("rd0", 8'h00, 1'b0, 8'h00, 16'h0000, 4'h0);
        redirect = 1'b0;
        tick(); chk_all("rf0", 8'h01, 1'b1, 8'h00, 16'h1234, 4'h1);
        tick(); chk_all("rf1", 8'h02, 1'b1, 8'h01, 16'h5678, 4'h5);

        // Stall three cycles
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_all("stall", 8'h02, 1'b1, 8'h01, 16'h5678, 4'h5);
        end
        stall = 1'b0;
        tick(); chk_all("resume", 8'h03, 1'b1, 8'h02, 16'h9ABC, 4'h9);

        // Redirect wins over simultaneous stall
        redirect = 1'b1; redirect_pc = 8'h40; stall = 1'b1;
        tick(); chk_all("rdst", 8'h40, 1'b0, 8'h00, 16'h0000, 4'h0);
        redirect = 1'b0; stall = 1'b0;
        tick(); chk_all("rdst1", 8'h41, 1'b1, 8'h40, 16'h7ABC, 4'h7);

        // PC wrap at 0xFF
        redirect = 1'b1; redirect_pc = 8'hFF;
        tick(); chk_all("wrap0", 8'hFF, 1'b0, 8'h00, 16'h0000, 4'h0);
        redirect = 1'b0;
        tick(); chk_all("wrap1", 8'h00, 1'b1, 8'hFF, 16'hC0FF, 4'hC);
        tick(); chk_all("wrap2", 8'h01, 1'b1, 8'h00, 16'h1234, 4'h1);

        // Mid-run reset while stalled at pc 0x23
        redirect = 1'b1; redirect_pc = 8'h23;
        tick(); chk("goto23", 32'(imem_addr), 32'h23);
        redirect = 1'b0; stall = 1'b1; rst = 1'b1;
        tick(); chk_all("mrst", 8'h00, 1'b0, 8'h00, 16'h0000, 4'h0);
        chk("mrst.imem_en", 32'(imem_en), 32'd0);
        // BOOT cycle ignores redirect and stall
        rst = 1'b0; redirect = 1'b1; redirect_pc = 8'h55;
        tick(); chk_all("mboot", 8'h00, 1'b0, 8'h00, 16'h0000, 4'h0);
        chk("mboot.imem_en", 32'(imem_en), 32'd1);
        redirect = 1'b0; stall = 1'b0;
        tick(); chk_all("mrun", 8'h01, 1'b1, 8'h00, 16'h1234, 4'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
